fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the word address fetched first after reset.
REQ-002 SHALL have parameter INSTR_W, default 32, the instruction width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port mem_en, output, 1, the read enable to instruction memory.
REQ-006 SHALL have port mem_addr, output, 32, the word address to instruction memory.
REQ-007 SHALL have port mem_rdata, input, INSTR_W, the memory data, valid one cycle after a mem_en=1 cycle.
REQ-008 SHALL have port branch_en, input, 1, the redirect request from decode/execute.
REQ-009 SHALL have port branch_target, input, 32, the redirect word address.
REQ-010 SHALL have port instr_valid, output, 1, meaning instr_data/instr_pc hold a valid instruction.
REQ-011 SHALL have port instr_ready, input, 1, meaning decode accepts this cycle.
REQ-012 SHALL have port instr_data, output, INSTR_W, the fetched instruction.
REQ-013 SHALL have port instr_pc, output, 32, the word address of instr_data.
REQ-014 SHALL have port halted, output, 1, the halt status (see Configuration).

Function
REQ-015 SHALL treat addresses as word addresses: sequential PC increments by 1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-016 SHALL issue a read (mem_en=1, mem_addr=PC, then PC<=PC+1) in any cycle where buffer occupancy + in-flight reads < 2, branch_en=0 and not halted; otherwise mem_en=0.
REQ-017 SHALL capture mem_rdata, with its issuing address, into a 2-entry FIFO on the cycle after issue, unless that read was squashed.
REQ-018 SHALL present the FIFO head on instr_data/instr_pc with instr_valid=1 whenever the FIFO is non-empty; an entry retires only on instr_valid & instr_ready.
REQ-019 SHALL give a minimum latency of 2 cycles: issue at cycle N, data in FIFO at N+1, instr_valid visible from N+1 after the capture edge.
REQ-020 SHALL keep instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-021 SHALL sustain one instruction per cycle with instr_ready held high.
REQ-022 SHALL never overflow: FIFO full plus instr_ready=0 blocks issue; capture and retire in the same cycle with FIFO full is legal.
REQ-023 SHALL on branch_en=1: PC<=branch_target, FIFO emptied, any in-flight read squashed (its data discarded next cycle), mem_en=0 that cycle; first target read issues the following cycle.
REQ-024 SHALL, when branch_en and an instr_valid&instr_ready handshake coincide, count the handshake as completed before the flush.
REQ-025 SHALL, on back-to-back branch_en cycles, honour only the latest branch_target.

Reset
REQ-026 SHALL on rst_n=0 immediately set PC=RESET_PC, mem_en=0, mem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, halted=0, FIFO empty, no in-flight read.
REQ-027 SHALL issue its first read (address RESET_PC) in the first rising edge cycle after rst_n deasserts.
REQ-028 SHALL discard any read in flight when reset asserts mid-operation.

Configuration
REQ-029 SHALL, with macro FETCH_HALT_EN defined, set halted=1 and stop issuing once an instruction equal to HALT_OPCODE retires; halted clears only on reset or branch_en.
REQ-030 SHALL, without FETCH_HALT_EN, tie halted to 0 and treat HALT_OPCODE as an ordinary instruction.

Structure
REQ-031 SHALL place RESET_PC default, INSTR_W default, HALT_OPCODE (32'hFFFF_FFFF) and the FIFO entry struct {pc, data} in shared package fetch_pkg.
REQ-032 SHALL implement the 2-entry FIFO as sub-module fetch_buf (push, pop, flush, full, empty, head).

Verification
REQ-033 Reset, memory [0]=32'h11, [1]=32'h22, instr_ready=1 -> mem_addr 0,1,2.. each cycle; instr_valid first high 2 cycles after reset release with 0x11 at pc 0, then 0x22 at pc 1.
REQ-034 instr_ready=0 for 5 cycles after first valid -> instr_data/instr_pc frozen, at most 2 reads issued total, no instruction lost or duplicated on release.
REQ-035 branch_en=1, branch_target=32'h40 with one read in flight -> squashed data never appears; next instr_valid shows pc 0x40.
REQ-036 branch_en coinciding with handshake of pc 5 -> pc 5 accepted exactly once, next instruction pc = target.
REQ-037 FETCH_HALT_EN defined, [3]=32'hFFFF_FFFF -> halted=1 after pc 3 retires, mem_en stays 0; without macro, pc 4 follows.
REQ-038 RESET_PC=32'hFFFF_FFFF -> fetch order pc FFFF_FFFF then 0; rst_n pulsed low mid-stream -> outputs cleared same cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default parameters,
// the halt opcode and the fetch buffer entry layout.
// Latency: n/a (definitions only). Backpressure: n/a.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INSTR_W_DEF  = 32;
  localparam logic [31:0] HALT_OPCODE  = 32'hFFFF_FFFF;

  // One buffered instruction together with the word address it came from.
  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_W_DEF-1:0] data;
  } fetch_entry_t;

  // Word-address successor; wraps 32'hFFFF_FFFF to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched instructions between memory and decode.
// Latency: a push is visible on head the cycle after the pushing edge.
// Backpressure: push while full is only accepted together with a pop; flush wins over push/pop.
//
// Ports: push/push_entry write, pop retires the head, flush empties,
//        full/empty status, head is the oldest entry (stale when empty).
module fetch_buf
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  input  logic   flush,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  entry_t     slot [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign do_pop  = pop & ~empty;
  // Capture into a full buffer is legal when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = slot[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt_q   <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_entry;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word-address reads into a 2-entry buffer, with branch redirect.
// Latency: 2 cycles issue-to-instr_valid; one instruction per cycle with instr_ready held high.
// Backpressure: issue only while buffered + in-flight (after this cycle's retire) < 2; never overflows.
//
// Optional feature: define FETCH_HALT_EN to stop fetching once HALT_OPCODE retires
// (halted clears on reset or branch_en). Without it halted is tied to 0.
//
// Ports: clk, rst_n (async active-low); mem_en/mem_addr/mem_rdata to instruction
//        memory (data one cycle after mem_en); branch_en/branch_target redirect;
//        instr_valid/instr_ready/instr_data/instr_pc to decode; halted status.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          INSTR_W  = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_en,
  output logic [31:0]        mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               branch_en,
  input  logic [31:0]        branch_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [31:0]        instr_pc,
  output logic               halted
);

  // Same layout as fetch_entry_t, resized to this instance's instruction width.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] data;
  } slot_t;

  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic        halted_q;

  logic        buf_full;
  logic        buf_empty;
  slot_t       head;
  slot_t       push_entry;
  logic        push;
  logic        pop;
  logic [1:0]  occ;
  logic [1:0]  pending;
  logic        issue;

  assign pop = ~buf_empty & instr_ready;

  // A read in flight is always captured next cycle unless a branch squashes it.
  assign push       = inflight_q & ~branch_en;
  assign push_entry = '{pc: inflight_pc_q, data: mem_rdata};

  // Occupancy after this cycle's retire plus the read still in flight must
  // leave room for one more capture, otherwise issuing could overflow.
  assign occ     = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
  assign pending = occ - 2'(pop) + 2'(inflight_q);
  // rst_n gates issue so mem_en reads 0 for the whole time reset is held.
  assign issue   = rst_n & ~branch_en & ~halted_q & (pending < 2'd2);

  assign mem_en   = issue;
  assign mem_addr = pc_q;

  assign instr_valid = ~buf_empty;
  assign instr_data  = buf_empty ? '0 : head.data;
  assign instr_pc    = buf_empty ? '0 : head.pc;
  assign halted      = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (branch_en) begin
      // The latest target always wins; the outstanding read is dropped by
      // clearing inflight_q so its data is ignored next cycle.
      pc_q       <= branch_target;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= next_pc(pc_q);
        inflight_pc_q <= pc_q;
      end
    end
  end

`ifdef FETCH_HALT_EN
  logic halt_hit;

  assign halt_hit = pop & (head.data == INSTR_W'(HALT_OPCODE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if (branch_en) begin
      halted_q <= 1'b0;
    end else if (halt_hit) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  fetch_buf #(
    .entry_t(slot_t)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (branch_en),
    .full      (buf_full),
    .empty     (buf_empty),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        instr_ready;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        halted;

  logic        rst_w_n;
  logic        ready_w;
  logic        branch_w;
  logic [31:0] target_w;
  logic        mem_en_w;
  logic [31:0] mem_addr_w;
  logic [31:0] mem_rdata_w;
  logic        valid_w;
  logic [31:0] data_w;
  logic [31:0] pc_w;
  logic        halted_w;

  int errors    = 0;
  int checks    = 0;
  int issue_cnt = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .branch_en(branch_en), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .halted(halted)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .mem_en(mem_en_w), .mem_addr(mem_addr_w),
    .mem_rdata(mem_rdata_w), .branch_en(branch_w), .branch_target(target_w),
    .instr_valid(valid_w), .instr_ready(ready_w), .instr_data(data_w),
    .instr_pc(pc_w), .halted(halted_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0011;
      32'd1:   return 32'h0000_0022;
      32'd3:   return 32'hFFFF_FFFF;
      default: return {4'hA, a[27:0]};
    endcase
  endfunction

  // Memory model: data one cycle after an enabled read, junk otherwise.
  always @(posedge clk) mem_rdata   <= mem_en   ? mem_word(mem_addr)   : 32'hBAD0_BAD0;
  always @(posedge clk) mem_rdata_w <= mem_en_w ? mem_word(mem_addr_w) : 32'hBAD0_BAD0;
  always @(posedge clk) if (mem_en) issue_cnt <= issue_cnt + 1;

  task automatic restart(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0; branch_en = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; instr_ready = rdy;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({mem_en, mem_addr, instr_valid, instr_data, instr_pc, halted} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got en=%b addr=%h v=%b d=%h pc=%h h=%b, expected all zero", mem_en, mem_addr, instr_valid, instr_data, instr_pc, halted);
    end
    checks++;
    if ({mem_en_w, mem_addr_w, valid_w} !== {1'b0, 32'hFFFF_FFFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_w: got en=%b addr=%h v=%b, expected en=0 addr=ffffffff v=0", mem_en_w, mem_addr_w, valid_w);
    end
  endtask

  task automatic test_stream();
    restart(1'b1); #1;
    checks++;
    if ({mem_en, mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL stream_first_issue: got en=%b addr=%h v=%b, expected en=1 addr=0 v=0", mem_en, mem_addr, instr_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_en, mem_addr, instr_valid} !== {1'b1, 32'h1, 1'b0}) begin
      errors++;
      $display("FAIL stream_second_issue: got en=%b addr=%h v=%b, expected en=1 addr=1 v=0", mem_en, mem_addr, instr_valid);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'(k), mem_word(32'(k))}) begin
        errors++;
        $display("FAIL stream k=%0d: got v=%b pc=%h d=%h, expected v=1 pc=%h d=%h", k, instr_valid, instr_pc, instr_data, 32'(k), mem_word(32'(k)));
      end
      if (k < 4) begin
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 32'(k + 2)}) begin
          errors++;
          $display("FAIL stream_addr k=%0d: got en=%b addr=%h, expected en=1 addr=%h", k, mem_en, mem_addr, 32'(k + 2));
        end
      end
    end
  endtask

  task automatic test_stall();
    int base;
    restart(1'b0);
    base = issue_cnt;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({instr_valid, instr_pc, instr_data, mem_en} !== {1'b1, 32'h0, 32'h11, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold c=%0d: got v=%b pc=%h d=%h en=%b, expected v=1 pc=0 d=11 en=0", c, instr_valid, instr_pc, instr_data, mem_en);
      end
    end
    checks++;
    if (issue_cnt - base !== 2) begin
      errors++;
      $display("FAIL stall_reads: got %0d reads, expected 2", issue_cnt - base);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'(k), mem_word(32'(k))}) begin
        errors++;
        $display("FAIL stall_release k=%0d: got v=%b pc=%h d=%h, expected pc=%h d=%h", k, instr_valid, instr_pc, instr_data, 32'(k), mem_word(32'(k)));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_squash();
    restart(1'b1);
    @(negedge clk);
    @(negedge clk);
    branch_en = 1'b1; branch_target = 32'h40; #1;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL squash_en: got en=%b, expected 0", mem_en);
    end
    @(negedge clk);
    branch_en = 1'b0; #1;
    checks++;
    if ({instr_valid, mem_en, mem_addr} !== {1'b0, 1'b1, 32'h40}) begin
      errors++;
      $display("FAIL squash_redirect: got v=%b en=%b addr=%h, expected v=0 en=1 addr=40", instr_valid, mem_en, mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL squash_leak: got v=1 pc=%h d=%h, expected v=0", instr_pc, instr_data);
    end
    @(negedge clk); #1;
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h40, mem_word(32'h40)}) begin
      errors++;
      $display("FAIL squash_target: got v=%b pc=%h d=%h, expected v=1 pc=40 d=%h", instr_valid, instr_pc, instr_data, mem_word(32'h40));
    end
  endtask

  task automatic test_back_to_back();
    restart(1'b1);
    repeat (3) @(negedge clk);
    branch_en = 1'b1; branch_target = 32'h80;
    @(negedge clk);
    branch_target = 32'h90; #1;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_en: got en=%b, expected 0", mem_en);
    end
    @(negedge clk);
    branch_en = 1'b0; #1;
    checks++;
    if ({mem_en, mem_addr, instr_valid} !== {1'b1, 32'h90, 1'b0}) begin
      errors++;
      $display("FAIL b2b_addr: got en=%b addr=%h v=%b, expected en=1 addr=90 v=0", mem_en, mem_addr, instr_valid);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 32'h90, mem_word(32'h90)}) begin
      errors++;
      $display("FAIL b2b_target: got v=%b pc=%h d=%h, expected v=1 pc=90 d=%h", instr_valid, instr_pc, instr_data, mem_word(32'h90));
    end
  endtask

  task automatic test_branch_handshake();
    int  seen5;
    bit  found;
    logic [31:0] first_pc;
    restart(1'b1);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #1;
      if (instr_valid && instr_pc == 32'h5) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hs_wait: got no pc 5 within 20 cycles, expected pc 5");
    end
    seen5 = 1;
    branch_en = 1'b1; branch_target = 32'h100;
    found = 0; first_pc = 32'hDEAD_DEAD;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      branch_en = 1'b0; #1;
      if (instr_valid) begin
        if (instr_pc == 32'h5) seen5++;
        first_pc = instr_pc;
        found    = 1;
      end
    end
    checks++;
    if (first_pc !== 32'h100) begin
      errors++;
      $display("FAIL hs_next_pc: got %h, expected 100", first_pc);
    end
    checks++;
    if (seen5 !== 1) begin
      errors++;
      $display("FAIL hs_once: got pc 5 accepted %0d times, expected 1", seen5);
    end
  endtask

  task automatic test_halt();
    bit found;
    restart(1'b1);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #1;
      if (instr_valid && instr_pc == 32'h3) found = 1;
    end
    checks++;
    if (!found || instr_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL halt_wait: got found=%0d d=%h, expected pc 3 with d=ffffffff", found, instr_data);
    end
    @(negedge clk); #1;
`ifdef FETCH_HALT_EN
    begin
      int base;
      checks++;
      if ({halted, mem_en} !== 2'b10) begin
        errors++;
        $display("FAIL halt_set: got halted=%b en=%b, expected halted=1 en=0", halted, mem_en);
      end
      base = issue_cnt;
      repeat (3) @(negedge clk);
      checks++;
      if (issue_cnt - base !== 0) begin
        errors++;
        $display("FAIL halt_stop: got %0d reads, expected 0", issue_cnt - base);
      end
      branch_en = 1'b1; branch_target = 32'h10;
      @(negedge clk);
      branch_en = 1'b0; #1;
      checks++;
      if ({halted, mem_en, mem_addr} !== {1'b0, 1'b1, 32'h10}) begin
        errors++;
        $display("FAIL halt_clear: got halted=%b en=%b addr=%h, expected halted=0 en=1 addr=10", halted, mem_en, mem_addr);
      end
    end
`else
    checks++;
    if ({halted, mem_en, instr_valid, instr_pc, instr_data} !== {1'b0, 1'b1, 1'b1, 32'h4, mem_word(32'h4)}) begin
      errors++;
      $display("FAIL halt_ordinary: got halted=%b en=%b v=%b pc=%h d=%h, expected halted=0 en=1 v=1 pc=4 d=%h", halted, mem_en, instr_valid, instr_pc, instr_data, mem_word(32'h4));
    end
`endif
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst_w_n = 1'b1; ready_w = 1'b1; #1;
    checks++;
    if ({mem_en_w, mem_addr_w} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL wrap_first: got en=%b addr=%h, expected en=1 addr=ffffffff", mem_en_w, mem_addr_w);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_addr_w !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got addr=%h, expected 0", mem_addr_w);
    end
    @(negedge clk); #1;
    checks++;
    if ({valid_w, pc_w, data_w} !== {1'b1, 32'hFFFF_FFFF, 32'hAFFF_FFFF}) begin
      errors++;
      $display("FAIL wrap_pc_max: got v=%b pc=%h d=%h, expected v=1 pc=ffffffff d=afffffff", valid_w, pc_w, data_w);
    end
    @(negedge clk); #1;
    checks++;
    if ({valid_w, pc_w, data_w} !== {1'b1, 32'h0, 32'h11}) begin
      errors++;
      $display("FAIL wrap_pc_zero: got v=%b pc=%h d=%h, expected v=1 pc=0 d=11", valid_w, pc_w, data_w);
    end
    @(negedge clk);
    rst_w_n = 1'b0; #1;
    checks++;
    if ({mem_en_w, mem_addr_w, valid_w, pc_w, data_w, halted_w} !== {1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_midreset: got en=%b addr=%h v=%b pc=%h d=%h h=%b, expected en=0 addr=ffffffff rest 0", mem_en_w, mem_addr_w, valid_w, pc_w, data_w, halted_w);
    end
    @(negedge clk);
    rst_w_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (valid_w !== 1'b0) begin
      errors++;
      $display("FAIL wrap_stale: got v=1 pc=%h d=%h, expected v=0", pc_w, data_w);
    end
    @(negedge clk); #1;
    checks++;
    if ({valid_w, pc_w, data_w} !== {1'b1, 32'hFFFF_FFFF, 32'hAFFF_FFFF}) begin
      errors++;
      $display("FAIL wrap_restart: got v=%b pc=%h d=%h, expected v=1 pc=ffffffff d=afffffff", valid_w, pc_w, data_w);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; branch_en = 1'b0; branch_target = 32'h0;
    rst_w_n = 1'b0; ready_w = 1'b0; branch_w = 1'b0; target_w = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_squash();
    test_back_to_back();
    test_branch_handshake();
    test_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
